riscv_run_ctrl: RTL
===================

# riscv_run_ctrl

Synthesizable run controller for the single-cycle RISC-V core. It replaces a fixed-length bench run with measured execution. On `start` it pulses the core's reset, then lets the core run. It snoops the register-file write port to capture a result register and detects program completion from a stalled PC (a self-loop such as `j .`). If the program does not complete, it stops the run on a cycle-count timeout. It sits beside the core top, drives the core's reset, and exposes status to a bench or debug bus.

## Interface
Parameters:
- `XLEN`, 32, datapath/PC width
- `RESULT_REG`, 28, architectural register index captured as the result
- `RST_CYCLES`, 2, cycles the core reset is held after `start` (≥1)
- `MAX_CYCLES`, 100, RUN-cycle budget before timeout (≥1)
- `HALT_STABLE`, 4, consecutive cycles with unchanged PC that count as halt (≥2)
- `CNT_W`, 16, cycle-counter width (must hold `MAX_CYCLES`)

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle run request
- `pc`  in  XLEN  core program counter
- `rf_we`  in  1  core register-file write enable
- `rf_waddr`  in  5  core register-file write address
- `rf_wdata`  in  XLEN  core register-file write data
- `core_reset`  out  1  reset driven to the core
- `busy`  out  1  high in RESET_CORE and RUN
- `done`  out  1  run finished (level)
- `timed_out`  out  1  run ended by budget exhaustion
- `result`  out  XLEN  last value written to `RESULT_REG`
- `result_valid`  out  1  `RESULT_REG` written at least once this run
- `cycles`  out  CNT_W  RUN cycles elapsed

## Operation
- Reset values: `core_reset`=1; `busy`, `done`, `timed_out`, `result_valid`=0; `result`=0; `cycles`=0. The state returns to IDLE.
- **IDLE:** `core_reset`=1. A `start` high moves the controller to RESET_CORE and clears `result`, `result_valid`, `cycles`, the stable counter, `done` and `timed_out`.
- **RESET_CORE:** `core_reset`=1 for exactly `RST_CYCLES` cycles, then the controller enters RUN.
- **RUN:**
  - `core_reset`=0 and `cycles` increments every cycle.
  - `pc_q` holds the PC from the previous cycle. The stable counter increments when `pc`==`pc_q` and clears otherwise.
  - The first RUN cycle loads `pc_q` and never counts as stable.
- **Result capture:** when `rf_we` is high, `rf_waddr`==`RESULT_REG` and `RESULT_REG`≠0, the controller loads `result`←`rf_wdata` and sets `result_valid`=1. Capture happens only in RUN. A write in the same cycle as halt or timeout detection is still captured.
- **Halt:** when the stable counter reaches `HALT_STABLE`, the controller enters DONE with `done`=1 and `timed_out`=0.
- **Timeout:** when `cycles` reaches `MAX_CYCLES`, the controller enters DONE with `done`=1 and `timed_out`=1. `cycles` then reads `MAX_CYCLES` and never exceeds it.
- **Simultaneous halt and timeout:** halt wins and `timed_out`=0.
- **DONE:** `core_reset`=1 (the core is frozen). All outputs hold. A `start` high behaves as in IDLE and begins a new run.
- `start` is ignored in RESET_CORE and RUN.
- With `RESULT_REG`=0, `result_valid` stays 0.

## Timing
- `start` sampled high at edge E0 → `busy`=1 after E0.
- `core_reset` stays 1 through edge E0+`RST_CYCLES`; it is 0 from then until DONE.
- `cycles` equals the number of RUN-cycle edges completed.
- `done`, `timed_out` and the final `cycles` update on the same edge as the transition; `busy` falls on that edge.
- The `result` capture update is registered: the value is visible one edge after the write cycle.
- Asserting `reset` mid-run forces all outputs to their reset values immediately, without waiting for a clock edge. `core_reset` therefore rises asynchronously.

## Configuration
- Macro `RUN_CTRL_EXPECT_EN`:
  - **Defined:** adds input `expected` (XLEN) and outputs `pass` and `fail`. On entry to DONE, `pass`=1 iff `timed_out`=0, `result_valid`=1 and `result`==`expected`; otherwise `fail`=1. Both clear on reset and on `start`, and are never both 1.
  - **Undefined:** these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Factorial program leaving 5! in x28, ending in `j .`, defaults → `done`=1, `result`=120, `result_valid`=1, `timed_out`=0, `cycles` < 100.
- Program that never repeats the PC, `MAX_CYCLES`=100 → `done`=1, `timed_out`=1, `cycles`=100, `core_reset`=1 afterwards.
- x28 written (0x55) in the same cycle the halt is detected → `result`=0x55, `timed_out`=0. Forced halt and timeout on the same edge → `timed_out`=0.
- Assert `reset` 10 cycles into RUN → `core_reset`=1 immediately and all outputs at reset values; `start` again → run completes normally with `result`=120.
- After DONE, pulse `start` → `done`/`result_valid`/`cycles` clear, and `core_reset` is held high for exactly 2 cycles. `start` pulses during RUN have no effect.
- With `RUN_CTRL_EXPECT_EN` defined: `expected`=120 → `pass`=1, `fail`=0. `expected`=121 → `fail`=1. Timeout run → `fail`=1.

Source files
------------

// File: rtl/riscv_run_ctrl_if.sv
// riscv_run_ctrl_if: bundle between the run controller and its environment.
// Carries the run handshake, the core snoop signals (pc / register-file write
// port), the core reset and the run status.
// Optional: RUN_CTRL_EXPECT_EN adds expected/pass/fail.
interface riscv_run_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic [XLEN-1:0]  pc;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             core_reset;
  logic             busy;
  logic             done;
  logic             timed_out;
  logic [XLEN-1:0]  result;
  logic             result_valid;
  logic [CNT_W-1:0] cycles;
`ifdef RUN_CTRL_EXPECT_EN
  logic [XLEN-1:0]  expected;
  logic             pass;
  logic             fail;

  modport master (
    output start, pc, rf_we, rf_waddr, rf_wdata, expected,
    input  core_reset, busy, done, timed_out, result, result_valid, cycles, pass, fail
  );
  modport slave (
    input  start, pc, rf_we, rf_waddr, rf_wdata, expected,
    output core_reset, busy, done, timed_out, result, result_valid, cycles, pass, fail
  );
`else
  modport master (
    output start, pc, rf_we, rf_waddr, rf_wdata,
    input  core_reset, busy, done, timed_out, result, result_valid, cycles
  );
  modport slave (
    input  start, pc, rf_we, rf_waddr, rf_wdata,
    output core_reset, busy, done, timed_out, result, result_valid, cycles
  );
`endif
endinterface

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: run controller for the single-cycle RISC-V core.
// On start it holds the core in reset for RST_CYCLES, then lets it run while
// snooping the register-file write port for RESULT_REG. The run ends when the
// PC stays unchanged for HALT_STABLE cycles (halt) or after MAX_CYCLES RUN
// cycles (timeout); halt wins when both happen on the same edge.
// Optional: RUN_CTRL_EXPECT_EN adds expected input and pass/fail outputs.
module riscv_run_ctrl #(
  parameter int XLEN        = 32,
  parameter int RESULT_REG  = 28,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 100,
  parameter int HALT_STABLE = 4,
  parameter int CNT_W       = 16
) (
  input logic            clk,
  input logic            reset,
  riscv_run_ctrl_if.slave bus
);

  localparam int ST_W = $clog2(HALT_STABLE + 1);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [4:0]       RES_ADDR   = 5'(RESULT_REG);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_CYCLES);
  localparam logic [ST_W-1:0]  HALT_CNT   = ST_W'(HALT_STABLE);
  localparam logic [RC_W-1:0]  RC_LAST    = RC_W'(RST_CYCLES - 1);
  localparam bit               CAPTURE_EN = (RESULT_REG != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET_CORE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [ST_W-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             done_q, done_d;
  logic             timed_out_q, timed_out_d;
  logic             busy_q, busy_d;
  logic             core_reset_q, core_reset_d;
  logic             halt, tmo;
`ifdef RUN_CTRL_EXPECT_EN
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
`endif

  // Next-state and next-output computation for the run FSM.
  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    pc_d           = pc_q;
    stable_d       = stable_q;
    cycles_d       = cycles_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    done_d         = done_q;
    timed_out_d    = timed_out_q;
    busy_d         = busy_q;
    core_reset_d   = core_reset_q;
    halt           = 1'b0;
    tmo            = 1'b0;
`ifdef RUN_CTRL_EXPECT_EN
    pass_d         = pass_q;
    fail_d         = fail_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d        = S_RESET_CORE;
          rst_cnt_d      = '0;
          stable_d       = '0;
          cycles_d       = '0;
          result_d       = '0;
          result_valid_d = 1'b0;
          done_d         = 1'b0;
          timed_out_d    = 1'b0;
          busy_d         = 1'b1;
          core_reset_d   = 1'b1;
`ifdef RUN_CTRL_EXPECT_EN
          pass_d         = 1'b0;
          fail_d         = 1'b0;
`endif
        end
      end

      S_RESET_CORE: begin
        if (rst_cnt_q == RC_LAST) begin
          state_d      = S_RUN;
          core_reset_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end

      S_RUN: begin
        cycles_d = cycles_q + CNT_W'(1);
        pc_d     = bus.pc;
        // cycles_q == 0 marks the first RUN cycle: pc_q is stale there.
        if (cycles_q == '0) begin
          stable_d = '0;
        end else if (bus.pc == pc_q) begin
          stable_d = stable_q + ST_W'(1);
        end else begin
          stable_d = '0;
        end

        if (CAPTURE_EN && bus.rf_we && (bus.rf_waddr == RES_ADDR)) begin
          result_d       = bus.rf_wdata;
          result_valid_d = 1'b1;
        end

        halt = (stable_d == HALT_CNT);
        tmo  = (cycles_d == MAX_CNT);
        if (halt || tmo) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          timed_out_d  = !halt;
          busy_d       = 1'b0;
          core_reset_d = 1'b1;
`ifdef RUN_CTRL_EXPECT_EN
          // Verdict uses the values being committed on this edge, so a
          // result written in the final cycle is judged too.
          pass_d = halt && result_valid_d && (result_d == bus.expected);
          fail_d = !(halt && result_valid_d && (result_d == bus.expected));
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset holds the core in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rst_cnt_q      <= '0;
      pc_q           <= '0;
      stable_q       <= '0;
      cycles_q       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      timed_out_q    <= 1'b0;
      busy_q         <= 1'b0;
      core_reset_q   <= 1'b1;
`ifdef RUN_CTRL_EXPECT_EN
      pass_q         <= 1'b0;
      fail_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      pc_q           <= pc_d;
      stable_q       <= stable_d;
      cycles_q       <= cycles_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
      timed_out_q    <= timed_out_d;
      busy_q         <= busy_d;
      core_reset_q   <= core_reset_d;
`ifdef RUN_CTRL_EXPECT_EN
      pass_q         <= pass_d;
      fail_q         <= fail_d;
`endif
    end
  end

  assign bus.core_reset   = core_reset_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timed_out    = timed_out_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.cycles       = cycles_q;
`ifdef RUN_CTRL_EXPECT_EN
  assign bus.pass         = pass_q;
  assign bus.fail         = fail_q;
`endif

endmodule
